// File: rtl/log_compact_unpack_pipe.sv
// Two-stage valid/ready decoder from compact posit-style log words to unpacked log fields.
// Optional LOG_UNPACK_SKID_EN adds a 2-entry input skid buffer with a registered in_ready.
module log_compact_unpack_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LS    = 1,
    localparam int unsigned M    = $clog2((WIDTH - 2) * (2 ** LS) + 1) + 1,
    localparam int unsigned F    = WIDTH - 3 - LS
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_bits,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic                out_isZero,
    output logic                out_isInf,
    output logic [M-1:0]        out_signedLogExp,
    output logic [F-1:0]        out_logFrac
);

    localparam int unsigned NW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] InfPattern = {1'b1, {(WIDTH - 1){1'b0}}};

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s1_adv, s1_space, s1_load;
    logic             head_valid;
    logic [WIDTH-1:0] head_bits;

    assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign s1_space = !s1_valid_q || s1_adv;

`ifdef LOG_UNPACK_SKID_EN
    logic [WIDTH-1:0] skid_mem_q [2];
    logic             skid_wr_q, skid_rd_q;
    logic [1:0]       skid_cnt_q, skid_cnt_d;
    logic             in_ready_q;
    logic             push_in, skid_push, skid_pop;

    // With an empty buffer the incoming word bypasses straight into S1.
    assign push_in    = in_valid && in_ready_q;
    assign head_valid = (skid_cnt_q != 2'd0) || push_in;
    assign head_bits  = (skid_cnt_q != 2'd0) ? skid_mem_q[skid_rd_q] : in_bits;
    assign s1_load    = head_valid && s1_space;
    assign skid_pop   = (skid_cnt_q != 2'd0) && s1_load;
    assign skid_push  = push_in && !((skid_cnt_q == 2'd0) && s1_load);
    assign in_ready   = in_ready_q;

    always_comb begin
        skid_cnt_d = skid_cnt_q;
        if (skid_push) skid_cnt_d = skid_cnt_d + 2'd1;
        if (skid_pop)  skid_cnt_d = skid_cnt_d - 2'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            skid_cnt_q <= 2'd0;
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            skid_cnt_q <= skid_cnt_d;
            in_ready_q <= (skid_cnt_d != 2'd2);
            if (skid_push) skid_wr_q <= ~skid_wr_q;
            if (skid_pop)  skid_rd_q <= ~skid_rd_q;
        end
    end

    always_ff @(posedge clock) begin
        if (skid_push) skid_mem_q[skid_wr_q] <= in_bits;
    end
`else
    assign head_valid = in_valid;
    assign head_bits  = in_bits;
    assign in_ready   = resetn && s1_space;
    assign s1_load    = head_valid && in_ready;
`endif

    // Stage 1 decode: specials, magnitude, regime run length and direction.
    logic             dec_zero, dec_inf, dec_sign, dec_run, run_open;
    logic [WIDTH-2:0] dec_r, dec_rinv, dec_neg;
    logic [NW-1:0]    dec_n;

    always_comb begin
        dec_sign = head_bits[WIDTH-1];
        dec_zero = (head_bits == '0);
        dec_inf  = (head_bits == InfPattern);
        dec_neg  = -head_bits[WIDTH-2:0];
        dec_r    = dec_sign ? dec_neg : head_bits[WIDTH-2:0];
        dec_run  = dec_r[WIDTH-2];
        dec_rinv = dec_run ? dec_r : ~dec_r;
    end

    always_comb begin
        dec_n    = '0;
        run_open = 1'b1;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (run_open && dec_rinv[i]) begin
                dec_n = dec_n + NW'(1);
            end else begin
                run_open = 1'b0;
            end
        end
    end

    // The top two magnitude bits are always regime or terminator, so only the tail is kept.
    logic             s1_zero_q, s1_inf_q, s1_sign_q, s1_run_q;
    logic [WIDTH-4:0] s1_r_q;
    logic [NW-1:0]    s1_n_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_run_q   <= 1'b0;
            s1_r_q     <= '0;
            s1_n_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_zero_q <= dec_zero;
                s1_inf_q  <= dec_inf;
                s1_sign_q <= dec_sign;
                s1_run_q  <= dec_run;
                s1_r_q    <= dec_r[WIDTH-4:0];
                s1_n_q    <= dec_n;
            end
        end
    end

    // Stage 2: drop the regime with a barrel shift, then assemble k*2^LS + e.
    logic [LS+F-1:0]     s2_ef;
    logic [LS-1:0]       s2_e;
    logic [F-1:0]        s2_frac;
    logic signed [M-1:0] s2_k, s2_exp;

    always_comb begin
        s2_ef   = s1_r_q << (s1_n_q - NW'(1));
        s2_e    = s2_ef[LS+F-1 -: LS];
        s2_frac = s2_ef[F-1:0];
        s2_k    = s1_run_q ? (M'(s1_n_q) - M'(1)) : -M'(s1_n_q);
        s2_exp  = (s2_k <<< LS) + M'(s2_e);
        if (s1_zero_q || s1_inf_q) begin
            s2_exp  = '0;
            s2_frac = '0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    logic          out_sign_q, out_zero_q, out_inf_q;
    logic [M-1:0]  out_exp_q;
    logic [F-1:0]  out_frac_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s2_valid_q <= 1'b0;
            out_sign_q <= 1'b0;
            out_zero_q <= 1'b0;
            out_inf_q  <= 1'b0;
            out_exp_q  <= '0;
            out_frac_q <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_adv) begin
                out_sign_q <= s1_sign_q;
                out_zero_q <= s1_zero_q;
                out_inf_q  <= s1_inf_q;
                out_exp_q  <= s2_exp;
                out_frac_q <= s2_frac;
            end
        end
    end

    assign out_valid        = s2_valid_q;
    assign out_sign         = out_sign_q;
    assign out_isZero       = out_zero_q;
    assign out_isInf        = out_inf_q;
    assign out_signedLogExp = out_exp_q;
    assign out_logFrac      = out_frac_q;

endmodule

// File: tb/tb_log_compact_unpack_pipe.sv
// Bench for log_compact_unpack_pipe: bit-walking posit decoder model, scoreboard, directed
// vectors, backpressure, randomized handshake and mid-stream reset.
module tb_log_compact_unpack_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned LS = 1;
    localparam int unsigned M  = 5;
    localparam int unsigned F  = 4;
`ifdef LOG_UNPACK_SKID_EN
    localparam int SkidEn = 1;
`else
    localparam int SkidEn = 0;
`endif

    logic         clock, resetn;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_bits;
    logic         out_sign, out_isZero, out_isInf;
    logic [M-1:0] out_signedLogExp;
    logic [F-1:0] out_logFrac;

    log_compact_unpack_pipe #(.WIDTH(W), .LS(LS)) u_dut (
        .clock            (clock),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_bits          (in_bits),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sign         (out_sign),
        .out_isZero       (out_isZero),
        .out_isInf        (out_isInf),
        .out_signedLogExp (out_signedLogExp),
        .out_logFrac      (out_logFrac)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           checks = 0, errors = 0;
    int           cyc = 0, n_push = 0, n_pop = 0;
    logic [W-1:0] q_bits [$];
    int           q_cyc [$];
    bit           lat_chk = 1'b0;
    bit           held = 1'b0;
    logic [3+M+F-1:0] held_val;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Walks the magnitude bit by bit: regime run, terminator, exponent, fraction.
    function automatic void model(input logic [W-1:0] b, output int sg, output int z,
                                  output int inf, output int ex, output int fr);
        int r, pos, run, n, e, k;
        sg = int'(b[W-1]); z = 0; inf = 0; ex = 0; fr = 0;
        if (b == 0) begin z = 1; sg = 0; return; end
        if (int'(b) == (1 << (W - 1))) begin inf = 1; sg = 1; return; end
        r = (sg != 0) ? ((1 << W) - int'(b)) : int'(b);
        r = r % (1 << (W - 1));
        pos = W - 2;
        run = (r >> pos) & 1;
        n = 0;
        while (pos >= 0 && ((r >> pos) & 1) == run) begin n++; pos--; end
        pos--;
        e = 0;
        for (int i = 0; i < LS; i++) begin
            e = e * 2 + ((pos >= 0) ? ((r >> pos) & 1) : 0);
            pos--;
        end
        for (int i = 0; i < F; i++) begin
            fr = fr * 2 + ((pos >= 0) ? ((r >> pos) & 1) : 0);
            pos--;
        end
        k = (run != 0) ? n - 1 : -n;
        ex = k * (1 << LS) + e;
    endfunction

    always @(negedge clock) begin
        int sg, z, inf, ex, fr, c;
        logic [W-1:0] b;
        if (!resetn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!(out_valid && {out_sign, out_isZero, out_isInf, out_signedLogExp,
                                    out_logFrac} == held_val)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0d fields=%h expected v=1 fields=%h",
                             out_valid, {out_sign, out_isZero, out_isInf, out_signedLogExp,
                             out_logFrac}, held_val);
                end
            end
            if (out_valid && out_ready) begin
                if (q_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_valid with no word expected");
                end else begin
                    b = q_bits.pop_front();
                    c = q_cyc.pop_front();
                    n_pop++;
                    model(b, sg, z, inf, ex, fr);
                    checks++;
                    if (int'(out_sign) != sg || int'(out_isZero) != z || int'(out_isInf) != inf
                        || int'($signed(out_signedLogExp)) != ex || int'(out_logFrac) != fr) begin
                        errors++;
                        $display("FAIL decode 0x%02h: got s=%0d z=%0d i=%0d exp=%0d frac=%0d, expected s=%0d z=%0d i=%0d exp=%0d frac=%0d",
                                 b, out_sign, out_isZero, out_isInf,
                                 $signed(out_signedLogExp), out_logFrac, sg, z, inf, ex, fr);
                    end
                    if (lat_chk) chk("latency", cyc - c, 2);
                end
            end
            if (in_valid && in_ready) begin
                q_bits.push_back(in_bits);
                q_cyc.push_back(cyc);
                n_push++;
            end
            held     = out_valid && !out_ready;
            held_val = {out_sign, out_isZero, out_isInf, out_signedLogExp, out_logFrac};
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [W-1:0] b);
        bit acc;
        int g;
        acc = 1'b0;
        g = 0;
        in_valid = 1'b1;
        in_bits  = b;
        while (!acc && g < 50) begin
            @(negedge clock);
            acc = in_ready;
            tick();
            g++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        int g;
        g = 0;
        while (q_bits.size() != 0 && g < budget) begin
            tick();
            g++;
        end
        chk("drain_empty", q_bits.size(), 0);
        tick();
    endtask

    logic [W-1:0] pin_b [10] = '{8'h40, 8'h50, 8'hC0, 8'h00, 8'h80,
                                 8'h7F, 8'h01, 8'h49, 8'h20, 8'hFF};
    int pin_s [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1};
    int pin_z [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int pin_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int pin_e [10] = '{0, 1, 0, 0, 0, 12, -12, 0, -2, -12};
    int pin_f [10] = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0};
    logic [W-1:0] bp [4] = '{8'h33, 8'hA5, 8'h6E, 8'h12};

    initial begin
        int sg, z, inf, ex, fr, idx, g, start;
        bit a;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bits = '0;

        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_fields", int'({out_sign, out_isZero, out_isInf, out_signedLogExp,
                                  out_logFrac}), 0);
        #10 resetn = 1'b1;
        #1;
        chk("in_ready_after_release", in_ready, (SkidEn != 0) ? 0 : 1);
        tick();
        chk("in_ready_first_clock", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            model(pin_b[i], sg, z, inf, ex, fr);
            checks++;
            if (sg != pin_s[i] || z != pin_z[i] || inf != pin_i[i] || ex != pin_e[i]
                || fr != pin_f[i]) begin
                errors++;
                $display("FAIL model_pin 0x%02h: got s=%0d z=%0d i=%0d exp=%0d frac=%0d, expected s=%0d z=%0d i=%0d exp=%0d frac=%0d",
                         pin_b[i], sg, z, inf, ex, fr, pin_s[i], pin_z[i], pin_i[i],
                         pin_e[i], pin_f[i]);
            end
        end

        // Directed stream, back to back, checking 2-cycle latency.
        lat_chk = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(pin_b[i]);
        drain(20);
        lat_chk = 1'b0;

        // Backpressure: 5 stalled cycles offering 4 words.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            in_bits  = bp[idx % 4];
            @(negedge clock);
            a = in_valid && in_ready;
            tick();
            if (a) idx++;
        end
        chk("bp_accepted", idx, (SkidEn != 0) ? 4 : 2);
        chk("bp_in_ready_low", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("in_ready_path_from_out_ready", in_ready, (SkidEn != 0) ? 0 : 1);
        for (int i = 0; i < idx; i++) begin
            @(negedge clock);
            chk("drain_no_gap", out_valid, 1);
        end
        @(negedge clock);
        chk("drain_done", out_valid, 0);
        tick();

        // Randomized valid/ready.
        start = n_push;
        g = 0;
        while (n_push - start < 10000 && g < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_bits   = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            g++;
        end
        chk("random_budget", int'(n_push - start >= 10000), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(100);
        chk("no_drop_no_dup", n_pop, n_push);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        chk("full_before_reset", out_valid, 1);
        #1 resetn = 1'b0;
        #1;
        chk("reset_mid_out_valid", out_valid, 0);
        chk("reset_mid_in_ready", in_ready, 0);
        chk("reset_mid_fields", int'({out_sign, out_isZero, out_isInf, out_signedLogExp,
                                      out_logFrac}), 0);
        q_bits.delete();
        q_cyc.delete();
        tick();
        tick();
        #2 resetn = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(8'h49);
        drain(20);
        lat_chk = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
